// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch stage.
package fetch_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc} buffer that parks an instruction fetched while decode was stalled.
module fetch_hold_buf #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic [INSTR_W-1:0] buf_instr,
  output logic [ADDR_W-1:0]  buf_pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_instr <= '0;
      buf_pc    <= '0;
    end else if (clear) begin
      buf_instr <= '0;
      buf_pc    <= '0;
    end else if (load) begin
      buf_instr <= load_instr;
      buf_pc    <= load_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, imem req/ack handshake, IF/ID register, stall hold and redirect drain.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_next,
  input  logic               pc_sel,
  input  logic               stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc
);

  fetch_state_e       state, state_d;
  logic [ADDR_W-1:0]  pc_d, drain_addr, drain_addr_d, ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic               ifid_valid_d;
  logic               buf_load, buf_clear;
  logic [INSTR_W-1:0] buf_instr;
  logic [ADDR_W-1:0]  buf_pc;

  assign pc_plus1  = pc + ADDR_W'(1);
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  fetch_hold_buf #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_hold_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_instr(imem_rdata),
    .load_pc   (pc),
    .buf_instr (buf_instr),
    .buf_pc    (buf_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drain_addr <= '0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      drain_addr <= drain_addr_d;
      ifid_valid <= ifid_valid_d;
      ifid_instr <= ifid_instr_d;
      ifid_pc    <= ifid_pc_d;
    end
  end

  // Redirect beats stall everywhere; a wrong-path request still in flight is drained, never withdrawn.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    drain_addr_d = drain_addr;
    ifid_valid_d = ifid_valid;
    ifid_instr_d = ifid_instr;
    ifid_pc_d    = ifid_pc;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    unique case (state)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          pc_d = pc_next;
          if (pc_sel) begin
            ifid_valid_d = 1'b0;
          end else if (!ifid_valid || !stall) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = imem_rdata;
            ifid_pc_d    = pc;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end else if (pc_sel) begin
          drain_addr_d = pc;
          ifid_valid_d = 1'b0;
          pc_d         = pc_next;
          state_d      = DRAIN;
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (pc_sel) begin
          buf_clear    = 1'b1;
          ifid_valid_d = 1'b0;
          pc_d         = pc_next;
          state_d      = FETCH;
        end else if (!stall) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = buf_instr;
          ifid_pc_d    = buf_pc;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        ifid_valid_d = 1'b0;
        if (pc_sel) pc_d = pc_next;
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: streaming, wait states, stall hold, redirect drain, wrap and async reset.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_next, target;
  logic        pc_sel, stall;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc, pc_plus1, ifid_instr, ifid_pc;
  logic        ifid_valid;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  // Upstream PC mux and a memory whose word at address a is 0xA5000000 ^ a.
  assign pc_next    = pc_sel ? target : pc_plus1;
  assign imem_rdata = 32'hA500_0000 ^ imem_addr;

  pc_fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_next   (pc_next),
    .pc_sel    (pc_sel),
    .stall     (stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .pc        (pc),
    .pc_plus1  (pc_plus1),
    .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr),
    .ifid_pc   (ifid_pc)
  );

  task automatic applyStimulus(input logic sel, input logic [31:0] tgt, input logic stl, input logic ack);
    pc_sel   = sel;
    target   = tgt;
    stall    = stl;
    imem_ack = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " pc"}, pc, 32'h0);
    checkOutput({tag, " req"}, {31'b0, imem_req}, 32'h0);
    checkOutput({tag, " ifid_valid"}, {31'b0, ifid_valid}, 32'h0);
    checkOutput({tag, " ifid_instr"}, ifid_instr, 32'h0);
    checkOutput({tag, " ifid_pc"}, ifid_pc, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    checkReset("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Zero-wait streaming from RESET_PC.
    step();
    checkOutput("first req", {31'b0, imem_req}, 32'h1);
    checkOutput("first addr", imem_addr, 32'h0);
    checkOutput("first valid low", {31'b0, ifid_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("stream ifid_pc %0d", i), ifid_pc, 32'(i));
      checkOutput($sformatf("stream valid %0d", i), {31'b0, ifid_valid}, 32'h1);
      checkOutput($sformatf("stream instr %0d", i), ifid_instr, 32'hA500_0000 + 32'(i));
    end
    step();
    checkOutput("pc before wait", pc, 32'h5);

    // Three-cycle ack delay at pc=5.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("wait req %0d", k), {31'b0, imem_req}, 32'h1);
      checkOutput($sformatf("wait addr %0d", k), imem_addr, 32'h5);
      checkOutput($sformatf("wait pc %0d", k), pc, 32'h5);
      checkOutput($sformatf("wait bubble %0d", k), {31'b0, ifid_valid}, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    checkOutput("after wait ifid_pc", ifid_pc, 32'h5);
    checkOutput("after wait valid", {31'b0, ifid_valid}, 32'h1);

    // Stall while IF/ID full at pc=8 parks that fetch in the hold buffer.
    step();
    step();
    checkOutput("pre-stall pc", pc, 32'h8);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    step();
    checkOutput("hold req", {31'b0, imem_req}, 32'h0);
    checkOutput("hold ifid_pc", ifid_pc, 32'h7);
    checkOutput("hold pc", pc, 32'h9);
    step();
    checkOutput("hold2 ifid_pc", ifid_pc, 32'h7);
    checkOutput("hold2 instr", ifid_instr, 32'hA500_0007);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    checkOutput("release ifid_pc", ifid_pc, 32'h8);
    checkOutput("release instr", ifid_instr, 32'hA500_0008);
    checkOutput("release addr", imem_addr, 32'h9);
    step();
    checkOutput("resume ifid_pc", ifid_pc, 32'h9);

    // Redirect with stall while in HOLD drops the buffered instruction.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    step();
    checkOutput("hold again req", {31'b0, imem_req}, 32'h0);
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b1);
    step();
    checkOutput("hold redirect valid", {31'b0, ifid_valid}, 32'h0);
    checkOutput("hold redirect addr", imem_addr, 32'h20);
    checkOutput("hold redirect req", {31'b0, imem_req}, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    checkOutput("target ifid_pc", ifid_pc, 32'h20);

    // Redirect while the request for pc=3 is unacked drains it.
    applyStimulus(1'b1, 32'h3, 1'b0, 1'b1);
    step();
    checkOutput("ack+sel discard", {31'b0, ifid_valid}, 32'h0);
    checkOutput("ack+sel pc", pc, 32'h3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    checkOutput("pending addr", imem_addr, 32'h3);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    step();
    checkOutput("drain addr", imem_addr, 32'h3);
    checkOutput("drain pc", pc, 32'h40);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    checkOutput("drain held addr", imem_addr, 32'h3);
    checkOutput("drain held req", {31'b0, imem_req}, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    checkOutput("drained valid", {31'b0, ifid_valid}, 32'h0);
    checkOutput("post drain addr", imem_addr, 32'h40);
    step();
    checkOutput("post drain ifid_pc", ifid_pc, 32'h40);
    checkOutput("post drain instr", ifid_instr, 32'hA500_0040);

    // PC wrap.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step();
    checkOutput("max pc", pc, 32'hFFFF_FFFF);
    checkOutput("pc_plus1 wrap", pc_plus1, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    checkOutput("wrapped pc", pc, 32'h0);
    checkOutput("max ifid_pc", ifid_pc, 32'hFFFF_FFFF);

    // Latest redirect wins while draining, then async reset mid-wait.
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b0);
    step();
    checkOutput("drain2 pc", pc, 32'h77);
    checkOutput("drain2 addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 32'h99, 1'b0, 1'b0);
    step();
    checkOutput("drain2 latest pc", pc, 32'h99);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkReset("async reset");
    step();
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    checkOutput("refetch addr", imem_addr, 32'h0);
    checkOutput("refetch req", {31'b0, imem_req}, 32'h1);
    step();
    checkOutput("refetch ifid_pc", ifid_pc, 32'h0);
    checkOutput("refetch valid", {31'b0, ifid_valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
